// File: rtl/lbp_fifo_pkg.sv
// Shared definitions for the LBP result FIFO: register map, register bit
// positions, the FIFO word view returned on DATA reads and the bus FSM states.
package lbp_fifo_pkg;

    localparam int unsigned CODE_W     = 8;
    localparam int unsigned VIEW_IDX_W = 8;
    localparam int unsigned THRESH_W   = 5;
    localparam int unsigned DROP_W     = 8;

    // Register offsets, selected by adr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_LEVEL_LSB = 0;
    localparam int unsigned ST_LEVEL_W   = 5;
    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_OVF       = 16;
    localparam int unsigned ST_UDF       = 17;
    localparam int unsigned ST_DROP_LSB  = 24;

    // CTRL bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLEAR  = 2;

    typedef struct packed {
        logic [VIEW_IDX_W-1:0] idx;
        logic [CODE_W-1:0]     code;
    } lbp_word_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/lbp_sync_fifo.sv
// DEPTH-entry synchronous FIFO with flush.
//   push/pop    : request strobes; push while full is accepted only with a pop
//   flush       : empties the FIFO, wins over push and pop
//   rd_data_c   : head entry (combinational)
//   full_c/empty_c : combinational flags decoded from level
//   level       : registered number of stored entries
module lbp_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);
    assign push_ok_c = push & ~flush & (~full_c | pop);
    assign pop_ok_c  = pop & ~flush & ~empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and level; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
        end
    end

endmodule

// File: rtl/lbp_result_fifo.sv
// Captures LBP comparison codes on the pixel-done strobe, tags them with a
// per-frame pixel index and buffers them for the SoC to drain over Wishbone.
//   wb_clk_i/wb_rst_ni : clock, async active-low reset
//   wbs_*              : Wishbone slave (DATA, STATUS, CTRL, THRESH)
//   pxl_done_i         : async pixel-done strobe; lbp_bits_i : code bits
//   frame_start_i      : async frame start level (rising edge zeroes index)
//   irq_o              : fill-level / overflow interrupt
module lbp_result_fifo
    import lbp_fifo_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IDX_W       = 8,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pxl_done_i,
    input  logic [7:0]  lbp_bits_i,
    input  logic        frame_start_i,
    output logic        irq_o
);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WORD_W = IDX_W + CODE_W;

    logic [SYNC_STAGES-1:0] done_sync;
    logic [SYNC_STAGES-1:0] fs_sync;
    logic                   done_prev;
    logic                   fs_prev;
    logic                   done_edge_c;
    logic                   fs_edge_c;

    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_use_c;
    logic                en;
    logic                irq_en;
    logic [THRESH_W-1:0] thresh;
    logic                ovf;
    logic                udf;
    logic [DROP_W-1:0]   drop_cnt;
    logic [DROP_W-1:0]   drop_base_c;

    wb_state_t   state_q;
    wb_state_t   state_d;
    logic        hit_c;
    logic        acc_c;
    logic        rd_c;
    logic        wr_c;
    logic [1:0]  reg_sel_c;

    logic        cap_c;
    logic        flush_c;
    logic        pop_c;
    logic        ovf_evt_c;
    logic        udf_evt_c;
    logic        ovf_clr_c;
    logic        udf_clr_c;
    logic        ctrl_wr_c;
    logic        thr_wr_c;

    logic [WORD_W-1:0] fifo_rd_c;
    logic              full_c;
    logic              empty_c;
    logic [LVL_W-1:0]  level;

    lbp_word_t   rd_view_c;
    logic [31:0] status_c;
    logic [31:0] ctrl_c;
    logic [31:0] rd_mux_c;
    logic        unused_c;

    assign unused_c = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // Synchronizers feeding rising-edge detectors
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done_sync <= '0;
            fs_sync   <= '0;
            done_prev <= 1'b0;
            fs_prev   <= 1'b0;
        end else begin
            done_sync <= (done_sync << 1) | SYNC_STAGES'(pxl_done_i);
            fs_sync   <= (fs_sync << 1) | SYNC_STAGES'(frame_start_i);
            done_prev <= done_sync[SYNC_STAGES-1];
            fs_prev   <= fs_sync[SYNC_STAGES-1];
        end
    end

    assign done_edge_c = done_sync[SYNC_STAGES-1] & ~done_prev;
    assign fs_edge_c   = fs_sync[SYNC_STAGES-1] & ~fs_prev;

    // Bus decode
    assign hit_c     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign reg_sel_c = wbs_adr_i[3:2];

    // Wishbone FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= WB_IDLE;
        else            state_q <= state_d;
    end

    // Wishbone FSM next state; an access is accepted only from IDLE
    always_comb begin
        state_d = state_q;
        acc_c   = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (hit_c) begin
                    state_d = WB_ACK;
                    acc_c   = 1'b1;
                end
            end
            WB_ACK: state_d = WB_IDLE;
        endcase
    end

    assign rd_c = acc_c & ~wbs_we_i;
    assign wr_c = acc_c & wbs_we_i;

    // Register side effects
    assign flush_c   = wr_c & (reg_sel_c == REG_CTRL) & wbs_dat_i[CTRL_CLEAR];
    assign ctrl_wr_c = wr_c & (reg_sel_c == REG_CTRL);
    assign thr_wr_c  = wr_c & (reg_sel_c == REG_THRESH);
    assign ovf_clr_c = wr_c & (reg_sel_c == REG_STATUS) & wbs_dat_i[ST_OVF];
    assign udf_clr_c = wr_c & (reg_sel_c == REG_STATUS) & wbs_dat_i[ST_UDF];
    assign pop_c     = rd_c & (reg_sel_c == REG_DATA) & ~empty_c;
    assign udf_evt_c = rd_c & (reg_sel_c == REG_DATA) & empty_c;
    assign cap_c     = done_edge_c & en;
    assign ovf_evt_c = cap_c & ~flush_c & full_c & ~pop_c;
    assign idx_use_c = fs_edge_c ? '0 : idx;
    // A fresh overflow wins over a same-cycle clear of the counter
    assign drop_base_c = ovf_clr_c ? '0 : drop_cnt;

    lbp_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .flush     (flush_c),
        .push      (cap_c),
        .pop       (pop_c),
        .wr_data   ({idx_use_c, lbp_bits_i}),
        .rd_data_c (fifo_rd_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .level     (level)
    );

    // Pixel index, control registers and sticky flags
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx      <= '0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= THRESH_W'(1);
            ovf      <= 1'b0;
            udf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // Index advances on every enabled capture, even one lost to overflow
            if (flush_c)        idx <= '0;
            else if (cap_c)     idx <= idx_use_c + IDX_W'(1);
            else if (fs_edge_c) idx <= '0;

            if (ctrl_wr_c) begin
                en     <= wbs_dat_i[CTRL_EN];
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end

            if (thr_wr_c) begin
                thresh <= (wbs_dat_i[THRESH_W-1:0] == '0) ? THRESH_W'(1)
                                                          : wbs_dat_i[THRESH_W-1:0];
            end

            if (flush_c)        ovf <= 1'b0;
            else if (ovf_evt_c) ovf <= 1'b1;
            else if (ovf_clr_c) ovf <= 1'b0;

            if (flush_c)        udf <= 1'b0;
            else if (udf_evt_c) udf <= 1'b1;
            else if (udf_clr_c) udf <= 1'b0;

            if (flush_c) begin
                drop_cnt <= '0;
            end else if (ovf_evt_c) begin
                drop_cnt <= (drop_base_c == '1) ? drop_base_c : drop_base_c + DROP_W'(1);
            end else if (ovf_clr_c) begin
                drop_cnt <= '0;
            end
        end
    end

    // Read data mux
    always_comb begin
        rd_view_c.idx  = VIEW_IDX_W'(fifo_rd_c[WORD_W-1:CODE_W]);
        rd_view_c.code = fifo_rd_c[CODE_W-1:0];

        status_c = '0;
        status_c[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(level);
        status_c[ST_EMPTY]                   = empty_c;
        status_c[ST_FULL]                    = full_c;
        status_c[ST_OVF]                     = ovf;
        status_c[ST_UDF]                     = udf;
        status_c[ST_DROP_LSB +: DROP_W]      = drop_cnt;

        ctrl_c = '0;
        ctrl_c[CTRL_EN]     = en;
        ctrl_c[CTRL_IRQ_EN] = irq_en;

        case (reg_sel_c)
            REG_DATA:   rd_mux_c = empty_c ? '0
                                   : {1'b1, 7'b0, rd_view_c.idx, 8'b0, rd_view_c.code};
            REG_STATUS: rd_mux_c = status_c;
            REG_CTRL:   rd_mux_c = ctrl_c;
            REG_THRESH: rd_mux_c = 32'(thresh);
            default:    rd_mux_c = '0;
        endcase
    end

    // Registered outputs; read data is only non-zero alongside ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            wbs_ack_o <= (state_d == WB_ACK);
            wbs_dat_o <= rd_c ? rd_mux_c : '0;
            irq_o     <= irq_en & ((32'(level) >= 32'(thresh)) | ovf);
        end
    end

endmodule

// File: tb/tb_lbp_result_fifo.sv
// Bench for lbp_result_fifo: directed scenarios plus a randomized phase, all
// checked against a queue-based reference model of the FIFO and registers.
module tb_lbp_result_fifo;

    localparam int unsigned DEPTH    = 16;
    localparam logic [31:0] A_DATA   = 32'h3000_0100;
    localparam logic [31:0] A_STATUS = 32'h3000_0104;
    localparam logic [31:0] A_CTRL   = 32'h3000_0108;
    localparam logic [31:0] A_THRESH = 32'h3000_010C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        done;
    logic [7:0]  bits;
    logic        fs;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model: each entry is idx*256 + code
    int mq[$];
    int m_idx;
    int m_drop;
    int m_thresh;
    bit m_ovf;
    bit m_udf;
    bit m_en;
    bit m_irq_en;

    always #5 clk = ~clk;

    lbp_result_fifo dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .pxl_done_i    (done),
        .lbp_bits_i    (bits),
        .frame_start_i (fs),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_idx    = 0;
        m_drop   = 0;
        m_thresh = 1;
        m_ovf    = 0;
        m_udf    = 0;
        m_en     = 0;
        m_irq_en = 0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        if (mq.size() == 0)     s |= 32'h0000_0100;
        if (mq.size() == DEPTH) s |= 32'h0000_0200;
        if (m_ovf)              s |= 32'h0001_0000;
        if (m_udf)              s |= 32'h0002_0000;
        s |= 32'(m_drop) << 24;
        return s;
    endfunction

    task automatic model_capture(input int code);
        if (m_en) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(m_idx * 256 + code);
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            m_idx = (m_idx + 1) % 256;
        end
    endtask

    // Single bus transfer; bounded wait for ack, then checks the bus idles
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r);
        bit got;
        got  = 0;
        r    = '0;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (ack === 1'b1) begin
                got = 1;
                r   = rdat;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout addr=%08h observed=no-ack expected=ack", a);
        end
        tick(1);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("dat_zero_idle", rdat, 32'd0);
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] v);
        logic [31:0] r;
        wb_xfer(1'b1, a, v, r);
        if (a == A_STATUS) begin
            if (v[16]) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (v[17]) m_udf = 0;
        end else if (a == A_CTRL) begin
            m_en     = v[0];
            m_irq_en = v[1];
            if (v[2]) begin
                mq.delete();
                m_idx  = 0;
                m_ovf  = 0;
                m_udf  = 0;
                m_drop = 0;
            end
        end else if (a == A_THRESH) begin
            m_thresh = (v[4:0] == 5'd0) ? 1 : int'(v[4:0]);
        end
    endtask

    task automatic read_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    function automatic logic [31:0] m_pop();
        int v;
        if (mq.size() == 0) begin
            m_udf = 1;
            return 32'd0;
        end
        v = mq.pop_front();
        return 32'h8000_0000 | 32'((v / 256) << 16) | 32'(v % 256);
    endfunction

    task automatic read_data(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        wb_xfer(1'b0, A_DATA, 32'd0, r);
        e = m_pop();
        check(tag, r, e);
    endtask

    task automatic read_status(input string tag);
        read_reg(tag, A_STATUS, m_status());
    endtask

    task automatic check_irq(input string tag);
        bit e;
        e = m_irq_en && ((mq.size() >= m_thresh) || m_ovf);
        check(tag, 32'(irq), 32'(e));
    endtask

    task automatic capture(input logic [7:0] code);
        bits = code;
        done = 1'b1;
        tick(4);
        done = 1'b0;
        tick(4);
        model_capture(int'(code));
    endtask

    task automatic frame_start();
        fs = 1'b1;
        tick(4);
        fs = 1'b0;
        tick(4);
        m_idx = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] e;
        int          op;

        rst_n = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 4'hF;
        adr   = 32'd0;
        wdat  = 32'd0;
        done  = 1'b0;
        bits  = 8'd0;
        fs    = 1'b0;
        m_reset();
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        read_status("rst_status");
        read_reg("rst_ctrl", A_CTRL, 32'd0);
        read_reg("rst_thresh", A_THRESH, 32'd1);

        // Basic capture with latency probe: push lands on the 3rd clock after the rise
        write_reg(A_CTRL, 32'h1);
        bits = 8'hA5;
        done = 1'b1;
        tick(2);
        check("lat_before", 32'(dut.level), 32'd0);
        tick(1);
        check("lat_at_3", 32'(dut.level), 32'd1);
        tick(1);
        done = 1'b0;
        tick(4);
        model_capture(8'hA5);
        read_data("cap_a5");
        capture(8'($urandom));
        read_data("cap_idx1");

        // Frame restart
        frame_start();
        repeat (5) capture(8'($urandom));
        frame_start();
        capture(8'($urandom));
        for (int i = 0; i < 6; i++) read_data("frame_read");

        // Overflow, then clear ovf and drop_cnt
        repeat (18) capture(8'($urandom));
        read_status("ovf_status");
        write_reg(A_STATUS, 32'h0001_0000);
        read_status("ovf_clr_status");

        // Full FIFO: DATA read coincident with a capture push
        bits = 8'($urandom);
        done = 1'b1;
        tick(2);
        wb_xfer(1'b0, A_DATA, 32'd0, r);
        e = m_pop();
        check("full_rd_push_data", r, e);
        done = 1'b0;
        tick(4);
        model_capture(int'(bits));
        check("full_rd_push_level", 32'(dut.level), 32'd16);
        read_status("full_rd_push_status");

        // Drain and underflow
        repeat (DEPTH) read_data("drain");
        read_data("udf_read");
        read_status("udf_status");
        write_reg(A_STATUS, 32'h0002_0000);
        read_status("udf_clr_status");

        // IRQ threshold
        write_reg(A_THRESH, 32'd4);
        write_reg(A_CTRL, 32'h3);
        check_irq("irq_0");
        for (int i = 0; i < 4; i++) begin
            capture(8'($urandom));
            check_irq("irq_fill");
        end
        read_data("irq_pop");
        check_irq("irq_after_pop");
        write_reg(A_THRESH, 32'd0);
        read_reg("thresh_zero", A_THRESH, 32'd1);
        check_irq("irq_thresh1");
        repeat (3) read_data("irq_drain");

        // CTRL.clear coincident with a capture push
        capture(8'($urandom));
        capture(8'($urandom));
        bits = 8'($urandom);
        done = 1'b1;
        tick(2);
        write_reg(A_CTRL, 32'h5);
        done = 1'b0;
        tick(4);
        read_status("clr_status");
        capture(8'h3C);
        read_data("clr_idx0");

        // Randomized mix against the model
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: capture(8'($urandom));
                4, 5:       read_data("rnd_data");
                6:          read_status("rnd_status");
                7:          write_reg(A_CTRL, {30'd0, 1'($urandom), 1'($urandom_range(0, 3) != 0)});
                8:          write_reg(A_THRESH, 32'($urandom_range(0, 20)));
                default: begin
                    if ($urandom_range(0, 1) == 0) frame_start();
                    else write_reg(A_STATUS, 32'($urandom_range(0, 3)) << 16);
                end
            endcase
            check_irq("rnd_irq");
        end

        // Reset asserted mid-read
        write_reg(A_CTRL, 32'h3);
        capture(8'h11);
        capture(8'h22);
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b0;
        adr = A_DATA;
        #2;
        rst_n = 1'b0;
        tick(1);
        check("rstmid_ack", 32'(ack), 32'd0);
        check("rstmid_dat", rdat, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        tick(1);
        rst_n = 1'b1;
        m_reset();
        tick(1);
        check("rstmid_irq", 32'(irq), 32'd0);
        read_status("rstmid_status");
        read_reg("rstmid_ctrl", A_CTRL, 32'd0);
        read_reg("rstmid_thresh", A_THRESH, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
